// File: rtl/reg10_share_arbiter.sv
// +-------------------------------------------------------------------------+
// | reg10_share_arbiter: round-robin, lockable time-sharing of one register |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

module reg10_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W        = 10,
  parameter int HOLD_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [N_REQ*W-1:0] data_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               ld,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [W-1:0]       reg_out
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_GRANT  = 1'b1;
  localparam logic [1:0] HOLD_LIM = 2'(HOLD_MAX);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       hold_q, hold_d;
  logic [W-1:0]     reg_q;
  logic [W-1:0]     slice_w;
  logic [1:0]       win_w;
  logic             any_req_w;
  logic             keep_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Scan from farthest to nearest so the requester right after last_q wins.
  always_comb begin
    logic [1:0] idx;
    idx   = 2'd0;
    win_w = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) win_w = idx;
    end
  end

  assign any_req_w = |req;
  assign keep_w    = (state_q == S_GRANT) && req[owner_q] && lock[owner_q] &&
                     (hold_q < HOLD_LIM);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (keep_w) begin
      hold_d = hold_q + 2'd1;
    end else if (any_req_w) begin
      state_d = S_GRANT;
      gnt_d   = N_REQ'(1) << win_w;
      owner_d = win_w;
      last_d  = win_w;
      hold_d  = 2'd1;
    end else begin
      state_d = S_IDLE;
      gnt_d   = '0;
      hold_d  = 2'd0;
    end
  end

  always_comb begin
    gnt     = gnt_q;
    ld      = |gnt_q;
    busy    = (state_q == S_GRANT);
    owner   = owner_q;
    reg_out = reg_q;
  end

  assign slice_w = data_in[W*owner_q +: W];

  // Shared register built from independent single-bit cells.
  for (genvar b = 0; b < W; b++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     reg_q[b] <= 1'b0;
      else if (ld) reg_q[b] <= slice_w[b];
    end
  end

endmodule

`default_nettype wire
